decode_stage: RTL
=================

Name: decode_stage

Overview:
- Parametrised successor of the pipeline decode stage; sits between the IF/ID and ID/EX pipeline registers.
- Reads the register file and generates a sign-extended immediate per RV32I format.
- Detects load-use hazards, inserts bubbles, accepts flushes, and drives a valid-qualified ID/EX pipeline register.

Parameters:
- XLEN, 32, datapath and PC width; legal values 32 or 64.
- NREGS, 32, architectural register count; legal values 16 or 32; index width RW = clog2(NREGS).

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ifid_valid  in  1  IF/ID holds a real instruction.
- ifid_inst  in  32  instruction word.
- ifid_pc  in  XLEN  PC of the instruction.
- flush  in  1  branch/jump redirect from EX; kills the instruction in ID.
- wb_we  in  1  writeback enable.
- wb_rd  in  RW  writeback destination.
- wb_data  in  XLEN  writeback value.
- stall  out  1  combinational; when high, IF and IF/ID must hold.
- idex_valid  out  1  ID/EX contents are a real instruction.
- idex_pc  out  XLEN  forwarded PC.
- idex_data1, idex_data2  out  XLEN  rs1 and rs2 read values.
- idex_rs1, idex_rs2, idex_rd  out  RW each  register indices, for forwarding in EX.
- idex_func7  out  7  inst[31:25].
- idex_func3  out  3  inst[14:12].
- idex_opcode  out  7  inst[6:0].
- idex_imm  out  XLEN  sign-extended immediate.
- idex_mem_read  out  1  instruction is a LOAD (opcode 0000011).

Behaviour:
- Reset: all idex_* outputs = 0; all registers = 0. The reset takes effect on the clock edge even mid-stall or mid-flush and overrides both.
- Latency: one cycle from IF/ID to ID/EX.
- Register file: 2 combinational read ports and 1 write port on the clock edge. Reads of x0 return 0; writes to x0 are discarded. Indices at or above NREGS read 0 and are not written.
- Immediate selection by opcode:
  - I-type: LOAD, OP-IMM, JALR.
  - S-type: STORE.
  - B-type: BRANCH; bit0 = 0.
  - U-type: LUI, AUIPC; low 12 bits 0.
  - J-type: JAL; bit0 = 0.
  - Any other opcode: 0.
  - Sign extension is from inst[31] to XLEN.
- Source usage: uses_rs1 for every opcode except LUI, AUIPC, JAL. uses_rs2 for OP, STORE, BRANCH only.
- Load-use hazard: hz = idex_valid & idex_mem_read & idex_rd!=0 & ((uses_rs1 & rs1==idex_rd) | (uses_rs2 & rs2==idex_rd)).
- stall = ifid_valid & hz & !flush.
- Priority on each clock edge:
  1. rst.
  2. flush: idex_valid <= 0; other fields don't-care, but idex_mem_read <= 0.
  3. stall: bubble; idex_valid <= 0, idex_mem_read <= 0.
  4. Otherwise: load all fields; idex_valid <= ifid_valid.
- When ifid_valid = 0, stall = 0 and a bubble is loaded.
- A stall lasts exactly 1 cycle per load, because the bubble clears hz.
- The regfile write proceeds regardless of stall or flush.

Optional Feature:
- Macro DECODE_WB_BYPASS_EN.
- Defined: a read port whose index equals wb_rd while wb_we=1 and wb_rd!=0 returns wb_data in the same cycle (write-through).
- Undefined: reads return the stored value. Add a WB hazard term to stall: wb_we & wb_rd!=0 & matching used source. The stall lasts one cycle, and the consumer then reads the written value.

Decomposition:
- Shared package decode_pkg holds:
  - opcode localparams (OPC_LOAD, OPC_OP_IMM, OPC_STORE, OPC_BRANCH, OPC_OP, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR);
  - imm_fmt_t enum {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE}.
- One sub-module, decode_regfile, parametrised on XLEN and NREGS, containing the register array and the bypass logic.
- Immediate generation and hazard logic stay inline.

Test Plan:
- Reset, then `ADDI x1,x0,-5` (0xFFB00093) with ifid_valid=1 -> next cycle idex_valid=1, idex_imm=0xFFFFFFFB, idex_rd=1, stall=0.
- WB writes x3=0x1234 then `ADD x4,x3,x0` -> idex_data1=0x1234. Same-cycle write and read: 0x1234 with DECODE_WB_BYPASS_EN; without it, stall=1 for one cycle, then 0x1234.
- `LW x5,0(x2)` followed by `ADD x6,x5,x1` -> stall=1 for 1 cycle and a bubble (idex_valid=0), then ADD issues; a LW to x0 causes no stall.
- flush=1 asserted during a load-use stall -> stall=0 and idex_valid=0 next cycle.
- `JAL x1,-4` (0xFFDFF0EF) -> idex_imm=0xFFFFFFFC; `LUI x7,0x12345` -> idex_imm=0x12345000; any write to x0 -> reads 0.
- XLEN=64 build: B-type negative offset -> 64-bit sign extension; rst asserted while a stall is active -> all outputs 0 next cycle.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32I opcodes, immediate formats and the
// per-opcode source-register usage used by the decode stage.
package decode_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_t;

    function automatic imm_fmt_t immFormat(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: immFormat = IMM_I;
            OPC_STORE:                      immFormat = IMM_S;
            OPC_BRANCH:                     immFormat = IMM_B;
            OPC_LUI, OPC_AUIPC:             immFormat = IMM_U;
            OPC_JAL:                        immFormat = IMM_J;
            default:                        immFormat = IMM_NONE;
        endcase
    endfunction

    function automatic logic usesRs1(input logic [6:0] opc);
        usesRs1 = !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
    endfunction

    function automatic logic usesRs2(input logic [6:0] opc);
        usesRs2 = (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bundles the IF/ID inputs, writeback port, flush/stall and the ID/EX
// pipeline register outputs of the decode stage.
interface decode_stage_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int RW = $clog2(NREGS);

    logic            ifid_valid;
    logic [31:0]     ifid_inst;
    logic [XLEN-1:0] ifid_pc;
    logic            flush;
    logic            wb_we;
    logic [RW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;

    logic            stall;
    logic            idex_valid;
    logic [XLEN-1:0] idex_pc;
    logic [XLEN-1:0] idex_data1;
    logic [XLEN-1:0] idex_data2;
    logic [RW-1:0]   idex_rs1;
    logic [RW-1:0]   idex_rs2;
    logic [RW-1:0]   idex_rd;
    logic [6:0]      idex_func7;
    logic [2:0]      idex_func3;
    logic [6:0]      idex_opcode;
    logic [XLEN-1:0] idex_imm;
    logic            idex_mem_read;

    modport master (
        output ifid_valid, ifid_inst, ifid_pc, flush, wb_we, wb_rd, wb_data,
        input  stall, idex_valid, idex_pc, idex_data1, idex_data2,
               idex_rs1, idex_rs2, idex_rd, idex_func7, idex_func3,
               idex_opcode, idex_imm, idex_mem_read
    );

    modport slave (
        input  ifid_valid, ifid_inst, ifid_pc, flush, wb_we, wb_rd, wb_data,
        output stall, idex_valid, idex_pc, idex_data1, idex_data2,
               idex_rs1, idex_rs2, idex_rd, idex_func7, idex_func3,
               idex_opcode, idex_imm, idex_mem_read
    );
endinterface

// File: rtl/decode_regfile.sv
// Register file with two combinational read ports and one clocked write port.
// Define DECODE_WB_BYPASS_EN to make a same-cycle write visible on the reads.
module decode_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int RW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      i_raddr1,
    input  logic [4:0]      i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2,
    input  logic            i_we,
    input  logic [RW-1:0]   i_waddr,
    input  logic [XLEN-1:0] i_wdata
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic [4:0]      w_raddr [2];
    logic [XLEN-1:0] w_rdata [2];

    assign w_raddr[0] = i_raddr1;
    assign w_raddr[1] = i_raddr2;
    assign o_rdata1   = w_rdata[0];
    assign o_rdata2   = w_rdata[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // x0 and indices beyond the implemented register count always read as zero
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rdata[p] = '0;
            if ((w_raddr[p] != 5'd0) && (int'(w_raddr[p]) < NREGS)) begin
                w_rdata[p] = r_regs[w_raddr[p][RW-1:0]];
`ifdef DECODE_WB_BYPASS_EN
                if (i_we && (i_waddr != '0) && (w_raddr[p][RW-1:0] == i_waddr)) begin
                    w_rdata[p] = i_wdata;
                end
`endif
            end
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Pipeline decode stage: regfile read, immediate generation, load-use stall and
// ID/EX register. DECODE_WB_BYPASS_EN selects write-through instead of a WB stall.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input logic           clk,
    input logic           rst,
    decode_stage_if.slave bus
);

    localparam int RW = $clog2(NREGS);

    logic [31:0]     w_inst;
    logic [6:0]      w_opc;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    imm_fmt_t        w_fmt;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_data1;
    logic [XLEN-1:0] w_data2;
    logic            w_use1;
    logic            w_use2;
    logic            w_ld_hit;
    logic            w_wb_hit;
    logic            w_stall;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_data1;
    logic [XLEN-1:0] r_data2;
    logic [RW-1:0]   r_rs1;
    logic [RW-1:0]   r_rs2;
    logic [RW-1:0]   r_rd;
    logic [6:0]      r_func7;
    logic [2:0]      r_func3;
    logic [6:0]      r_opcode;
    logic [XLEN-1:0] r_imm;
    logic            r_mem_read;

    assign w_inst = bus.ifid_inst;
    assign w_opc  = w_inst[6:0];
    assign w_rs1  = w_inst[19:15];
    assign w_rs2  = w_inst[24:20];
    assign w_rd   = w_inst[11:7];
    assign w_fmt  = immFormat(w_opc);
    assign w_use1 = usesRs1(w_opc);
    assign w_use2 = usesRs2(w_opc);

    decode_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .RW    (RW)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (w_data1),
        .o_rdata2 (w_data2),
        .i_we     (bus.wb_we),
        .i_waddr  (bus.wb_rd),
        .i_wdata  (bus.wb_data)
    );

    // Built at 32 bits, then sign-extended from inst[31] to XLEN
    always_comb begin
        w_imm32 = '0;
        case (w_fmt)
            IMM_I:   w_imm32 = {{20{w_inst[31]}}, w_inst[31:20]};
            IMM_S:   w_imm32 = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
            IMM_B:   w_imm32 = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25],
                                w_inst[11:8], 1'b0};
            IMM_U:   w_imm32 = {w_inst[31:12], 12'b0};
            IMM_J:   w_imm32 = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20],
                                w_inst[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign w_imm = XLEN'($signed(w_imm32));

    assign w_ld_hit = r_valid && r_mem_read && (r_rd != '0) &&
                      ((w_use1 && (w_rs1 == 5'(r_rd))) || (w_use2 && (w_rs2 == 5'(r_rd))));

`ifdef DECODE_WB_BYPASS_EN
    assign w_wb_hit = 1'b0;
`else
    // Without write-through, a same-cycle writeback to a used source waits one cycle
    assign w_wb_hit = bus.wb_we && (bus.wb_rd != '0) &&
                      ((w_use1 && (w_rs1 == 5'(bus.wb_rd))) ||
                       (w_use2 && (w_rs2 == 5'(bus.wb_rd))));
`endif

    assign w_stall   = bus.ifid_valid && (w_ld_hit || w_wb_hit) && !bus.flush;
    assign bus.stall = w_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_data1    <= '0;
            r_data2    <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_func7    <= '0;
            r_func3    <= '0;
            r_opcode   <= '0;
            r_imm      <= '0;
            r_mem_read <= 1'b0;
        end else if (bus.flush || w_stall) begin
            r_valid    <= 1'b0;
            r_mem_read <= 1'b0;
        end else begin
            r_valid    <= bus.ifid_valid;
            r_pc       <= bus.ifid_pc;
            r_data1    <= w_data1;
            r_data2    <= w_data2;
            r_rs1      <= w_rs1[RW-1:0];
            r_rs2      <= w_rs2[RW-1:0];
            r_rd       <= w_rd[RW-1:0];
            r_func7    <= w_inst[31:25];
            r_func3    <= w_inst[14:12];
            r_opcode   <= w_opc;
            r_imm      <= w_imm;
            r_mem_read <= bus.ifid_valid && (w_opc == OPC_LOAD);
        end
    end

    assign bus.idex_valid    = r_valid;
    assign bus.idex_pc       = r_pc;
    assign bus.idex_data1    = r_data1;
    assign bus.idex_data2    = r_data2;
    assign bus.idex_rs1      = r_rs1;
    assign bus.idex_rs2      = r_rs2;
    assign bus.idex_rd       = r_rd;
    assign bus.idex_func7    = r_func7;
    assign bus.idex_func3    = r_func3;
    assign bus.idex_opcode   = r_opcode;
    assign bus.idex_imm      = r_imm;
    assign bus.idex_mem_read = r_mem_read;

endmodule
